// File: rtl/ff_credit_arbiter_pkg.sv
// Shared constants and helpers for the credit-based round-robin arbiter slice.
// Datapath width and the grant-index width live here so every file agrees on them.
package ff_credit_arbiter_pkg;

   localparam int PATH_WIDTH    = 32;
   localparam int FF_ARB_MAX_IN = 8;
   localparam int GRANT_W       = $clog2(FF_ARB_MAX_IN);

   typedef logic [GRANT_W-1:0] grant_t;

   // Slot visited 'step' positions after 'ptr' in a ring of numIn requesters.
   function automatic int nextSlot(input grant_t ptr, input int step, input int numIn);
      return (int'(ptr) + step) % numIn;
   endfunction

endpackage

// File: rtl/ff_credit_arbiter_if.sv
// Upstream/downstream handshake bundle of ff_credit_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface ff_credit_arbiter_if
   import ff_credit_arbiter_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int DATA_W = PATH_WIDTH
);

   logic [NUM_IN-1:0]        i_valid;
   logic [NUM_IN*DATA_W-1:0] i_data;
   logic [NUM_IN-1:0]        o_credit;
   logic                     i_credit;
   logic                     o_valid;
   logic [DATA_W-1:0]        o_data;
   grant_t                   o_grantId;
   logic                     o_err;

   modport slave (
      input  i_valid, i_data, i_credit,
      output o_credit, o_valid, o_data, o_grantId, o_err
   );

   modport master (
      output i_valid, i_data, i_credit,
      input  o_credit, o_valid, o_data, o_grantId, o_err
   );

endinterface

// File: rtl/ff_credit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request found after i_ptr, wrapping.
// The pointer itself is owned by the caller so idle cycles leave priority untouched.
module rr_arbiter
   import ff_credit_arbiter_pkg::*;
#(
   parameter int NUM_IN = 4
) (
   input  logic [NUM_IN-1:0] i_req,
   input  grant_t            i_ptr,
   output logic [NUM_IN-1:0] o_gnt,
   output grant_t            o_idx,
   output logic              o_any
);

   int w_cand;

   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = 0;
      for (int k = 1; k <= NUM_IN; k++) begin
         w_cand = nextSlot(i_ptr, k, NUM_IN);
         for (int i = 0; i < NUM_IN; i++) begin
            if (!o_any && (i == w_cand) && i_req[i]) begin
               o_any    = 1'b1;
               o_gnt[i] = 1'b1;
               o_idx    = grant_t'(i);
            end
         end
      end
   end

endmodule

// File: rtl/ff_credit_arbiter.sv
// Shares one credit-based downstream link among NUM_IN requesters, each with a
// one-entry holding register, using round-robin selection gated by downstream credits.
module ff_credit_arbiter
   import ff_credit_arbiter_pkg::*;
#(
   parameter int NUM_IN  = 4,
   parameter int DATA_W  = PATH_WIDTH,
   parameter int CREDITS = 2,
   parameter int CNT_W   = 4
) (
   input logic               clk,
   input logic               rst_n,
   ff_credit_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] MAX_CREDITS = CNT_W'(CREDITS);

   logic [NUM_IN-1:0] r_holdFull;
   logic [DATA_W-1:0] r_holdData [NUM_IN];
   logic [CNT_W-1:0]  r_credits;
   grant_t            r_ptr;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   grant_t            r_grant;
   logic [NUM_IN-1:0] r_creditOut;
   logic              r_err;

   logic [NUM_IN-1:0] w_eligible;
   logic [NUM_IN-1:0] w_gnt;
   grant_t            w_winIdx;
   logic              w_any;
   logic [DATA_W-1:0] w_winData;
   logic              w_overflow;
   logic              w_creditOverflow;

   assign w_eligible = (r_credits != '0) ? r_holdFull : '0;

   rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
      .i_req (w_eligible),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_winIdx),
      .o_any (w_any)
   );

   always_comb begin
      w_winData = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (w_gnt[i]) w_winData = r_holdData[i];
      end
   end

   // A launching hold still counts as full: its upstream credit is only now going back.
   assign w_overflow       = |(bus.i_valid & r_holdFull);
   assign w_creditOverflow = bus.i_credit && !w_any && (r_credits == MAX_CREDITS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_holdFull <= '0;
         for (int i = 0; i < NUM_IN; i++) r_holdData[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (w_gnt[i]) begin
               r_holdFull[i] <= 1'b0;
            end else if (bus.i_valid[i] && !r_holdFull[i]) begin
               r_holdFull[i] <= 1'b1;
               r_holdData[i] <= bus.i_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credits <= MAX_CREDITS;
      end else begin
         case ({bus.i_credit, w_any})
            2'b10:   if (r_credits != MAX_CREDITS) r_credits <= r_credits + 1'b1;
            2'b01:   r_credits <= r_credits - 1'b1;
            default: r_credits <= r_credits;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_grant     <= '0;
         r_creditOut <= '0;
         r_ptr       <= grant_t'(NUM_IN - 1);
         r_err       <= 1'b0;
      end else begin
         r_valid     <= w_any;
         r_creditOut <= w_gnt;
         if (w_any) begin
            r_data  <= w_winData;
            r_grant <= w_winIdx;
            r_ptr   <= w_winIdx;
         end
         if (w_overflow || w_creditOverflow) r_err <= 1'b1;
      end
   end

   assign bus.o_valid   = r_valid;
   assign bus.o_data    = r_data;
   assign bus.o_grantId = r_grant;
   assign bus.o_credit  = r_creditOut;
   assign bus.o_err     = r_err;

endmodule

// File: tb/tb_ff_credit_arbiter.sv
// Directed self-checking bench for ff_credit_arbiter (NUM_IN=4, DATA_W=32, CREDITS=2).
// Inputs change and outputs are checked on the falling clock edge.
module tb_ff_credit_arbiter;
   import ff_credit_arbiter_pkg::*;

   localparam int NUM_IN = 4;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   ff_credit_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) bus ();

   ff_credit_arbiter #(
      .NUM_IN  (NUM_IN),
      .DATA_W  (DATA_W),
      .CREDITS (2),
      .CNT_W   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag, input logic expValid, input logic [31:0] expData,
                              input logic [2:0] expGrant, input logic [3:0] expCredit, input logic expErr);
      checkField({tag, ".valid"},  32'(bus.o_valid),   32'(expValid));
      checkField({tag, ".data"},   bus.o_data,         expData);
      checkField({tag, ".grant"},  32'(bus.o_grantId), 32'(expGrant));
      checkField({tag, ".credit"}, 32'(bus.o_credit),  32'(expCredit));
      checkField({tag, ".err"},    32'(bus.o_err),     32'(expErr));
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic creditIn);
      bus.i_valid  = valid;
      bus.i_credit = creditIn;
   endtask

   task automatic setData(input int idx, input logic [31:0] value);
      bus.i_data[idx*DATA_W +: DATA_W] = value;
   endtask

   task automatic nextCycle;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] fairData [4];
      fairData[0] = 32'h11111111;
      fairData[1] = 32'h22222222;
      fairData[2] = 32'h33333333;
      fairData[3] = 32'h44444444;

      bus.i_valid  = '0;
      bus.i_data   = '0;
      bus.i_credit = 1'b0;

      // Reset held for two cycles
      rst_n = 1'b0;
      repeat (2) nextCycle;
      checkOutput("reset", 1'b0, 32'h0, 3'd0, 4'b0000, 1'b0);
      rst_n = 1'b1;
      nextCycle;
      checkOutput("postReset", 1'b0, 32'h0, 3'd0, 4'b0000, 1'b0);

      // Single input: capture edge then launch edge, no credit_in needed
      setData(0, 32'hDEADBEEF);
      applyStimulus(4'b0001, 1'b0);
      nextCycle;
      applyStimulus(4'b0000, 1'b0);
      checkOutput("single.capture", 1'b0, 32'h0, 3'd0, 4'b0000, 1'b0);
      nextCycle;
      checkOutput("single.launch", 1'b1, 32'hDEADBEEF, 3'd0, 4'b0001, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      nextCycle;
      applyStimulus(4'b0000, 1'b0);
      checkOutput("single.after", 1'b0, 32'hDEADBEEF, 3'd0, 4'b0000, 1'b0);

      // Fairness from a fresh reset, credit returned alongside every launch
      rst_n = 1'b0;
      nextCycle;
      rst_n = 1'b1;
      checkOutput("fair.reset", 1'b0, 32'h0, 3'd0, 4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) setData(i, fairData[i]);
      applyStimulus(4'b1111, 1'b0);
      nextCycle;
      applyStimulus(4'b0000, 1'b1);
      for (int k = 0; k < 4; k++) begin
         nextCycle;
         if (k == 3) applyStimulus(4'b0000, 1'b0);
         checkOutput($sformatf("fair%0d", k), 1'b1, fairData[k], 3'(k), 4'(1 << k), 1'b0);
      end
      nextCycle;
      checkOutput("fair.idle", 1'b0, 32'h44444444, 3'd3, 4'b0000, 1'b0);

      // Credit exhaustion: two launches, then input 2 waits for a credit
      setData(0, 32'hA0A0A0A0);
      setData(1, 32'hA1A1A1A1);
      setData(2, 32'hA2A2A2A2);
      applyStimulus(4'b0111, 1'b0);
      nextCycle;
      applyStimulus(4'b0000, 1'b0);
      nextCycle;
      checkOutput("exh0", 1'b1, 32'hA0A0A0A0, 3'd0, 4'b0001, 1'b0);
      nextCycle;
      checkOutput("exh1", 1'b1, 32'hA1A1A1A1, 3'd1, 4'b0010, 1'b0);
      nextCycle;
      checkOutput("exh.stall", 1'b0, 32'hA1A1A1A1, 3'd1, 4'b0000, 1'b0);
      nextCycle;
      checkOutput("exh.stall2", 1'b0, 32'hA1A1A1A1, 3'd1, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      nextCycle;
      applyStimulus(4'b0000, 1'b0);
      checkOutput("exh.credit", 1'b0, 32'hA1A1A1A1, 3'd1, 4'b0000, 1'b0);
      nextCycle;
      checkOutput("exh2", 1'b1, 32'hA2A2A2A2, 3'd2, 4'b0100, 1'b0);

      // Counter at 1, credit_in coincides with a launch
      setData(0, 32'hB0B0B0B0);
      setData(3, 32'hB3B3B3B3);
      applyStimulus(4'b1001, 1'b1);
      nextCycle;
      applyStimulus(4'b0000, 1'b1);
      checkOutput("sim.setup", 1'b0, 32'hA2A2A2A2, 3'd2, 4'b0000, 1'b0);
      nextCycle;
      applyStimulus(4'b0000, 1'b0);
      checkOutput("sim3", 1'b1, 32'hB3B3B3B3, 3'd3, 4'b1000, 1'b0);
      nextCycle;
      checkOutput("sim0", 1'b1, 32'hB0B0B0B0, 3'd0, 4'b0001, 1'b0);
      nextCycle;
      checkOutput("sim.idle", 1'b0, 32'hB0B0B0B0, 3'd0, 4'b0000, 1'b0);

      // Overflow on input 1 keeps the first value
      setData(1, 32'hC1C1C1C1);
      applyStimulus(4'b0010, 1'b0);
      nextCycle;
      setData(1, 32'hC2C2C2C2);
      checkOutput("err.first", 1'b0, 32'hB0B0B0B0, 3'd0, 4'b0000, 1'b0);
      nextCycle;
      applyStimulus(4'b0000, 1'b0);
      checkOutput("err.set", 1'b0, 32'hB0B0B0B0, 3'd0, 4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      nextCycle;
      applyStimulus(4'b0000, 1'b0);
      checkOutput("err.credit", 1'b0, 32'hB0B0B0B0, 3'd0, 4'b0000, 1'b1);
      nextCycle;
      checkOutput("err.data", 1'b1, 32'hC1C1C1C1, 3'd1, 4'b0010, 1'b1);

      // Asynchronous reset while input 3 is still held
      setData(2, 32'hD2D2D2D2);
      setData(3, 32'hD3D3D3D3);
      applyStimulus(4'b1100, 1'b1);
      nextCycle;
      applyStimulus(4'b0000, 1'b0);
      checkOutput("rst.pre", 1'b0, 32'hC1C1C1C1, 3'd1, 4'b0000, 1'b1);
      @(posedge clk);
      #2;
      checkOutput("rst.launch", 1'b1, 32'hD2D2D2D2, 3'd2, 4'b0100, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst.async", 1'b0, 32'h0, 3'd0, 4'b0000, 1'b0);
      nextCycle;
      nextCycle;
      rst_n = 1'b1;
      nextCycle;
      checkOutput("rst.discard1", 1'b0, 32'h0, 3'd0, 4'b0000, 1'b0);
      nextCycle;
      checkOutput("rst.discard2", 1'b0, 32'h0, 3'd0, 4'b0000, 1'b0);

      // Two launches without credit_in prove the counter is back at CREDITS
      setData(0, 32'hE0E0E0E0);
      setData(1, 32'hE1E1E1E1);
      applyStimulus(4'b0011, 1'b0);
      nextCycle;
      applyStimulus(4'b0000, 1'b0);
      nextCycle;
      checkOutput("rst.cnt0", 1'b1, 32'hE0E0E0E0, 3'd0, 4'b0001, 1'b0);
      nextCycle;
      checkOutput("rst.cnt1", 1'b1, 32'hE1E1E1E1, 3'd1, 4'b0010, 1'b0);
      nextCycle;
      checkOutput("rst.cnt2", 1'b0, 32'hE1E1E1E1, 3'd1, 4'b0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
